// File: rtl/counter_pkg.sv
// counter_pkg: shared direction encoding and elaboration-time parameter legality check.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic bit params_ok(input int width, input longint modulus, input longint reset_val);
        return width >= 1 && width <= 31 && modulus >= 2 && modulus <= (longint'(1) << width)
            && reset_val >= 0 && reset_val < modulus;
    endfunction

endpackage

// File: rtl/mod_n_updown_counter_step.sv
// mod_n_step: combinational next count and boundary-crossing detect for a modulo-N up/down counter.
module mod_n_step
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic at_max, at_zero, up;

    always_comb begin
        up      = up_dn_i == DIR_UP;
        at_max  = q_i == MAX_Q;
        at_zero = q_i == '0;
        wrap_o  = up ? at_max : at_zero;
        nxt_o   = up ? (at_max ? '0 : q_i + WIDTH'(1)) : (at_zero ? MAX_Q : q_i - WIDTH'(1));
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: programmable modulo-N up/down counter with clear, load and wrap/load-error pulses.
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_bad_params
        $fatal(1, "mod_n_updown_counter: illegal WIDTH/MODULUS/RESET_VAL");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d, step_nxt;
    logic             wrap_q, wrap_d, lerr_q, lerr_d, step_wrap, load_ok;

    mod_n_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
        .q_i    (cnt_q),
        .up_dn_i(up_dn),
        .nxt_o  (step_nxt),
        .wrap_o (step_wrap)
    );

    // Priority: clr > load > en > hold; out-of-range loads saturate to the top value.
    always_comb begin
        load_ok = {1'b0, load_val} < MOD_W;
        cnt_d   = clr ? '0 : load ? (load_ok ? load_val : MAX_Q) : en ? step_nxt : cnt_q;
        wrap_d  = !clr && !load && en && step_wrap;
        lerr_d  = !clr && load && !load_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RST_Q;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    assign q        = cnt_q;
    assign tc       = (up_dn == DIR_DOWN) ? cnt_q == '0 : cnt_q == MAX_Q;
    assign wrap     = wrap_q;
    assign load_err = lerr_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter: two counter instances (mod-10 reset 0, mod-16 reset 5) on shared stimulus vs an integer model.
module tb_mod_n_updown_counter;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] qa, qb;
    logic       tca, tcb, wa, wb, lea, leb;
    int         n_checks = 0, n_fail = 0;
    int         ma = 0, mb = 5;
    bit         mwa, mla, mwb, mlb;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
        .q(qa), .tc(tca), .wrap(wa), .load_err(lea)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(5)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
        .q(qb), .tc(tcb), .wrap(wb), .load_err(leb)
    );

    task automatic step_model(input int m, input int rv, inout int q, inout bit w, inout bit le);
        bit w_n = 0, le_n = 0;
        if (rst) q = rv;
        else if (clr) q = 0;
        else if (load) begin
            if (int'(load_val) < m) q = int'(load_val);
            else begin q = m - 1; le_n = 1; end
        end else if (en) begin
            w_n = up_dn ? q == m - 1 : q == 0;
            q   = (q + (up_dn ? 1 : m - 1)) % m;
        end
        w  = w_n;
        le = le_n;
    endtask

    function automatic logic [6:0] expv(input int q, input int m, input bit w, input bit le);
        logic t;
        t = up_dn ? q == m - 1 : q == 0;
        return {q[3:0], t, w, le};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            step_model(10, 0, ma, mwa, mla);
            step_model(16, 5, mb, mwb, mlb);
            #1;
        end
    endtask

    task automatic test_reset();
        #20;
        n_checks++;
        if ({qa, tca, wa, lea} !== expv(ma, 10, 0, 0)) begin
            n_fail++; $display("FAIL reset_a got %b want %b", {qa, tca, wa, lea}, expv(ma, 10, 0, 0));
        end
        n_checks++;
        if ({qb, tcb, wb, leb} !== expv(mb, 16, 0, 0)) begin
            n_fail++; $display("FAIL reset_b got %b want %b", {qb, tcb, wb, leb}, expv(mb, 16, 0, 0));
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_checks++;
            if ({qa, tca, wa, lea} !== expv(ma, 10, mwa, mla)) begin
                n_fail++; $display("FAIL count_up_a step %0d got %b want %b", i, {qa, tca, wa, lea}, expv(ma, 10, mwa, mla));
            end
            n_checks++;
            if ({qb, tcb, wb, leb} !== expv(mb, 16, mwb, mlb)) begin
                n_fail++; $display("FAIL count_up_b step %0d got %b want %b", i, {qb, tcb, wb, leb}, expv(mb, 16, mwb, mlb));
            end
        end
    endtask

    task automatic test_count_down();
        clr = 1'b1; tick(); clr = 1'b0;
        up_dn = 1'b0; en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            n_checks++;
            if ({qa, tca, wa, lea} !== expv(ma, 10, mwa, mla)) begin
                n_fail++; $display("FAIL count_down_a step %0d got %b want %b", i, {qa, tca, wa, lea}, expv(ma, 10, mwa, mla));
            end
            n_checks++;
            if (qb !== 4'((16 - i % 16) % 16) || wb !== (i % 16 == 1) || tcb !== (i % 16 == 0)) begin
                n_fail++; $display("FAIL mod16_down step %0d got q=%0d wrap=%b tc=%b want q=%0d wrap=%b tc=%b",
                                   i, qb, wb, tcb, (16 - i % 16) % 16, i % 16 == 1, i % 16 == 0);
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] lv [3] = '{4'd7, 4'd12, 4'd3};
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; clr = (i == 2); en = 1'b1; up_dn = 1'b1; load_val = lv[i];
            tick();
            load = 1'b0; clr = 1'b0; en = 1'b0;
            n_checks++;
            if ({qa, tca, wa, lea} !== expv(ma, 10, mwa, mla)) begin
                n_fail++; $display("FAIL load_a val %0d got %b want %b", lv[i], {qa, tca, wa, lea}, expv(ma, 10, mwa, mla));
            end
            n_checks++;
            if ({qb, tcb, wb, leb} !== expv(mb, 16, mwb, mlb)) begin
                n_fail++; $display("FAIL load_b val %0d got %b want %b", lv[i], {qb, tcb, wb, leb}, expv(mb, 16, mwb, mlb));
            end
            tick();
            n_checks++;
            if (lea !== 1'b0) begin
                n_fail++; $display("FAIL load_err_pulse val %0d got %b want 0", lv[i], lea);
            end
        end
    endtask

    task automatic test_hold_dir();
        load = 1'b1; load_val = 4'd5; tick(); load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (qa !== 4'd5 || wa !== 1'b0) begin
                n_fail++; $display("FAIL hold step %0d got q=%0d wrap=%b want q=5 wrap=0", i, qa, wa);
            end
        end
        en = 1'b1; up_dn = 1'b0; tick();
        n_checks++;
        if (qa !== 4'd4) begin n_fail++; $display("FAIL dir_down got %0d want 4", qa); end
        up_dn = 1'b1; tick(); en = 1'b0;
        n_checks++;
        if (qa !== 4'd5) begin n_fail++; $display("FAIL dir_up got %0d want 5", qa); end
        load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
        n_checks++;
        if (tca !== 1'b1) begin n_fail++; $display("FAIL tc_up_at_9 got %b want 1", tca); end
        up_dn = 1'b0; #1;
        n_checks++;
        if (tca !== 1'b0) begin n_fail++; $display("FAIL tc_flip got %b want 0", tca); end
    endtask

    task automatic test_async_reset();
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up_dn = 1'b0; tick();
        n_checks++;
        if ({qa, wa, qb, wb} !== {4'd9, 1'b1, 4'd15, 1'b1}) begin
            n_fail++; $display("FAIL pre_reset_wrap got %b want %b", {qa, wa, qb, wb}, {4'd9, 1'b1, 4'd15, 1'b1});
        end
        #3 rst = 1'b1;
        #1;
        ma = 0; mb = 5; mwa = 0; mla = 0; mwb = 0; mlb = 0;
        n_checks++;
        if ({qa, wa, lea, qb, wb, leb} !== {4'd0, 2'b00, 4'd5, 2'b00}) begin
            n_fail++; $display("FAIL async_reset got %b want %b", {qa, wa, lea, qb, wb, leb}, {4'd0, 2'b00, 4'd5, 2'b00});
        end
        #2 rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 3) != 0;
            up_dn = 1'($urandom);
            clr = $urandom_range(0, 15) == 0;
            load = $urandom_range(0, 7) == 0;
            load_val = 4'($urandom);
            tick();
            n_checks++;
            if ({qa, tca, wa, lea} !== expv(ma, 10, mwa, mla)) begin
                n_fail++; $display("FAIL random_a cyc %0d got %b want %b", i, {qa, tca, wa, lea}, expv(ma, 10, mwa, mla));
            end
            n_checks++;
            if ({qb, tcb, wb, leb} !== expv(mb, 16, mwb, mlb)) begin
                n_fail++; $display("FAIL random_b cyc %0d got %b want %b", i, {qb, tcb, wb, leb}, expv(mb, 16, mwb, mlb));
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_hold_dir();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Parametrised modulo-N binary counter that counts up or down, selected at run time. It generalises the fixed mod-16 down counter with a programmable width, modulus and reset value. It adds count enable, synchronous clear, parallel load and terminal-count/wrap status outputs. It is the standard counter primitive for dividers, timers and address sequencers in the lab designs.

Parameters:
WIDTH, 4, counter register width in bits; must be >= 1.
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH.
RESET_VAL, 0, value loaded into q on reset; must be < MODULUS.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active high.
en  input  1  count enable; counts one step per clk edge when high.
up_dn  input  1  direction: 1 = count up, 0 = count down.
clr  input  1  synchronous clear to 0.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value to load.
q  output  WIDTH  current count.
tc  output  1  terminal count, combinational: q==MODULUS-1 when up_dn=1, q==0 when up_dn=0.
wrap  output  1  registered one-cycle pulse; high in the cycle after a count step crossed the boundary.
load_err  output  1  registered one-cycle pulse; high in the cycle after a load with load_val >= MODULUS.

Behaviour:
- Reset: rst high forces q=RESET_VAL, wrap=0 and load_err=0 immediately, independent of clk. Deassertion takes effect at the next clk edge.
- Synchronous priority per edge: clr > load > en > hold.
- clr=1: q<=0. wrap and load_err are 0 next cycle.
- load=1 (clr=0): if load_val < MODULUS, q<=load_val; otherwise q<=MODULUS-1 and load_err<=1. wrap is 0 next cycle. en is ignored.
- en=1 (clr=0, load=0), up: q<=q+1, except q==MODULUS-1 gives q<=0 and wrap<=1.
- en=1 (clr=0, load=0), down: q<=q-1, except q==0 gives q<=MODULUS-1 and wrap<=1.
- en=0 with no clr or load: q holds, wrap<=0, load_err<=0.
- Latency: q reflects a request one edge later. wrap and load_err are asserted together with the post-wrap/post-load q value.
- tc is purely combinational from q and up_dn. A direction change flips tc in the same cycle.
- Arithmetic is in WIDTH bits with explicit modulus compare. When MODULUS==2**WIDTH, natural overflow gives the same result; no extra logic relies on it.
- Direction change mid-count takes effect on the next enabled edge with no skipped or repeated value.
- Reset asserted mid-count aborts the operation. No pulse survives reset.

Decomposition:
- Shared package counter_pkg holds DIR_UP=1'b1 and DIR_DOWN=1'b0.
- The package also holds a function for the legal-parameter check (MODULUS range, RESET_VAL < MODULUS), evaluated at elaboration and failing with $fatal.
- One sub-module, mod_n_step: combinational next-value and wrap-detect from q, up_dn and MODULUS. The top holds the register, the priority mux and the status flops.

Test Plan:
1. Reset and count up: WIDTH=4, MODULUS=10; hold rst 20 ns, then en=1, up_dn=1 -> q = 0,1,...,9,0. wrap is high only in the cycle with q=0 after 9. tc is high while q=9.
2. Count down: MODULUS=10, up_dn=0 from q=0 -> q=9 next edge with wrap=1, then 8,7,... tc is high while q=0.
3. Default mod-16 down: WIDTH=4, MODULUS=16, up_dn=0 -> q = 0,15,14,...,1,0 repeating. Matches the legacy mod-16 down counter sequence.
4. Load: MODULUS=10, load_val=7 -> q=7 with load_err=0. Load with load_val=12 -> q=9 and load_err pulses for one cycle. load and clr asserted together -> q=0.
5. Hold and direction change: at q=5, en=0 for 3 cycles -> q stays 5. Set up_dn=0 with en=1 -> q=4. Set up_dn=1 -> q=5.
6. Async reset mid-count: at q=6, assert rst between clk edges -> q=RESET_VAL immediately with no clk edge, and wrap=0.
